game_fsm: RTL and testbench

// Parametrised game-flow controller for the runner display pipeline. Sequences

---
 rtl/game_pkg.sv | 26 ++
 rtl/lane_ctrl.sv | 82 ++++++++
 rtl/game_fsm.sv | 164 ++++++++++++++++
 tb/tb_game_fsm.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and helpers for the runner game-flow controller.
package game_pkg;

    // Width of every layer offset (two's complement, wraps on overflow).
    localparam int OFF_W = 12;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        LOGO      = 3'd2,
        SLIDE     = 3'd3,
        PLAY      = 3'd4,
        OVER      = 3'd5
    } game_state_t;

    // Number of set bits in a vector of up to 32 bits.
    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/lane_ctrl.sv
// Player lane control: button press detection on frame ticks, lane register
// bounded to [0, LANES-1], and the registered horizontal offset of the player.
module lane_ctrl
    import game_pkg::*;
#(
    parameter int LANES      = 3,
    parameter int LANE_PITCH = 100
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick_i,
    input  logic                      btn_left_i,
    input  logic                      btn_right_i,
    input  logic                      btn_start_i,
    input  logic                      move_en_i,
    input  logic                      centre_i,
    output logic                      start_press_o,
    output logic [$clog2(LANES)-1:0]  lane_o,
    output logic signed [OFF_W-1:0]   hoff_o
);

    localparam int LANE_W = $clog2(LANES);
    localparam logic [LANE_W-1:0] CENTRE = LANE_W'((LANES - 1) / 2);
    localparam logic [LANE_W-1:0] LAST   = LANE_W'(LANES - 1);

    // Previous-tick button samples, ordered {left, right, start}.
    logic [2:0]               prev_q, prev_d;
    logic [LANE_W-1:0]        lane_q, lane_d;
    logic signed [OFF_W-1:0]  hoff_q, hoff_d;
    logic                     press_l, press_r;

    // Signed pixel offset of a lane relative to the centre lane.
    function automatic logic signed [OFF_W-1:0] lane_offset(input logic [LANE_W-1:0] lane);
        int d;
        d = (int'(lane) - int'(CENTRE)) * LANE_PITCH;
        return OFF_W'(d);
    endfunction

    // A press is a rising edge between consecutive tick samples.
    assign press_l       = btn_left_i  & ~prev_q[2];
    assign press_r       = btn_right_i & ~prev_q[1];
    assign start_press_o = btn_start_i & ~prev_q[0];

    // Next lane and offset; simultaneous left+right presses cancel.
    always_comb begin
        // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
        prev_d = prev_q;
        lane_d = lane_q;
        hoff_d = hoff_q;
        if (tick_i) begin
            prev_d = {btn_left_i, btn_right_i, btn_start_i};
            if (centre_i) begin
                lane_d = CENTRE;
            end else if (move_en_i && (press_l != press_r)) begin
                if (press_l && lane_q != '0) begin
                    lane_d = lane_q - LANE_W'(1);
                end else if (press_r && lane_q != LAST) begin
                    lane_d = lane_q + LANE_W'(1);
                end
            end
            hoff_d = lane_offset(lane_d);
        end
    end

    // Lane state registers with synchronous reset to the centre lane.
    always_ff @(posedge clk) begin
        // NOTE: state is written with <= so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            prev_q <= '0;
            lane_q <= CENTRE;
            hoff_q <= '0;
        end else begin
            prev_q <= prev_d;
            lane_q <= lane_d;
            hoff_q <= hoff_d;
        end
    end

    assign lane_o = lane_q;
    assign hoff_o = hoff_q;

endmodule

// File: rtl/game_fsm.sv
// Game-flow controller: IDLE -> countdown -> logo fade -> slide-in -> play ->
// game over, with score, lives and post-hit invulnerability bookkeeping.
module game_fsm
    import game_pkg::*;
#(
    parameter int LANES         = 3,
    parameter int LANE_PITCH    = 100,
    parameter int N_COIN        = 3,
    parameter int N_OBST        = 4,
    parameter int SCORE_W       = 16,
    parameter int LIVES         = 3,
    parameter int COUNT_FRAMES  = 5,
    parameter int FADE_STEP     = 30,
    parameter int FADE_END      = 640,
    parameter int SLIDE_START   = 180,
    parameter int SLIDE_STEP    = 20,
    parameter int SLIDE_END     = 50,
    parameter int INVULN_FRAMES = 60
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_tick,
    input  logic                      btn_left,
    input  logic                      btn_right,
    input  logic                      btn_start,
    input  logic [N_COIN-1:0]         coin_hit,
    input  logic [N_OBST-1:0]         obst_hit,
    output game_state_t               state,
    output logic [$clog2(LANES)-1:0]  player_lane,
    output logic signed [OFF_W-1:0]   player_hoff,
    output logic [OFF_W-1:0]          player_voff,
    output logic [OFF_W-1:0]          logo_voff,
    output logic [SCORE_W-1:0]        score,
    output logic [3:0]                lives,
    output logic                      invuln,
    output logic                      spawn_en
);

    localparam int CNT_W = $clog2(COUNT_FRAMES + 1);
    localparam int INV_W = $clog2(INVULN_FRAMES + 1);

    game_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OFF_W-1:0]     logo_q, logo_d;
    logic [OFF_W-1:0]     pvoff_q, pvoff_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [3:0]           lives_q, lives_d;
    logic [INV_W-1:0]     inv_q, inv_d;
    logic                 spawn_q, spawn_d;
    logic                 invuln_q, invuln_d;
    logic [SCORE_W:0]     score_sum;
    logic                 start_press;
    logic                 restart;

    // A start press in IDLE or OVER begins a fresh game and recentres the player.
    assign restart = frame_tick && start_press && (state_q == IDLE || state_q == OVER);

    lane_ctrl #(
        .LANES      (LANES),
        .LANE_PITCH (LANE_PITCH)
    ) u_lane_ctrl (
        .clk           (clk),
        .rst           (rst),
        .tick_i        (frame_tick),
        .btn_left_i    (btn_left),
        .btn_right_i   (btn_right),
        .btn_start_i   (btn_start),
        .move_en_i     (state_q == PLAY),
        .centre_i      (restart),
        .start_press_o (start_press),
        .lane_o        (player_lane),
        .hoff_o        (player_hoff)
    );

    // Next-state, ramps, score, lives and invulnerability; all gated by frame_tick.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        logo_d    = logo_q;
        pvoff_d   = pvoff_q;
        score_d   = score_q;
        lives_d   = lives_q;
        inv_d     = inv_q;
        score_sum = {1'b0, score_q} + (SCORE_W + 1)'(popcount(32'(coin_hit)));

        if (frame_tick) begin
            case (state_q)
                IDLE, OVER: begin
                end
                COUNTDOWN: begin
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                    else             state_d = LOGO;
                end
                LOGO: begin
                    if (logo_q < OFF_W'(FADE_END)) logo_d = logo_q + OFF_W'(FADE_STEP);
                    else                           state_d = SLIDE;
                end
                SLIDE: begin
                    if (pvoff_q > OFF_W'(SLIDE_END)) pvoff_d = pvoff_q - OFF_W'(SLIDE_STEP);
                    else                             state_d = PLAY;
                end
                PLAY: begin
                    score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                    if ((|obst_hit) && inv_q == '0) begin
                        // Losing the last life ends the game; no protection window is started.
                        lives_d = lives_q - 4'd1;
                        if (lives_q == 4'd1) state_d = OVER;
                        else                 inv_d = INV_W'(INVULN_FRAMES);
                    end else if (inv_q != '0) begin
                        inv_d = inv_q - INV_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase

            if (restart) begin
                state_d = COUNTDOWN;
                cnt_d   = CNT_W'(COUNT_FRAMES);
                logo_d  = '0;
                pvoff_d = OFF_W'(SLIDE_START);
                score_d = '0;
                lives_d = 4'(LIVES);
                inv_d   = '0;
            end
        end

        spawn_d  = (state_d == PLAY);
        invuln_d = (inv_d != '0);
    end

    // Game state registers with synchronous reset to the idle screen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            logo_q   <= '0;
            pvoff_q  <= OFF_W'(SLIDE_START);
            score_q  <= '0;
            lives_q  <= 4'(LIVES);
            inv_q    <= '0;
            spawn_q  <= 1'b0;
            invuln_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            logo_q   <= logo_d;
            pvoff_q  <= pvoff_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
            inv_q    <= inv_d;
            spawn_q  <= spawn_d;
            invuln_q <= invuln_d;
        end
    end

    assign state       = state_q;
    assign player_voff = pvoff_q;
    assign logo_voff   = logo_q;
    assign score       = score_q;
    assign lives       = lives_q;
    assign invuln      = invuln_q;
    assign spawn_en    = spawn_q;

endmodule

// File: tb/tb_game_fsm.sv
// Scoreboard bench for game_fsm: a driver applies directed and random frame
// ticks and queues the reference model's expected outputs; a monitor pops and
// compares one entry after every clock edge that saw rst or frame_tick.
module tb_game_fsm;
    import game_pkg::*;

    localparam int LANES        = 3;
    localparam int PITCH        = 100;
    localparam int SCORE_W      = 4;
    localparam int SMAX         = 15;
    localparam int LIVES        = 3;
    localparam int COUNT_FRAMES = 5;
    localparam int FADE_STEP    = 30;
    localparam int FADE_END     = 640;
    localparam int SLIDE_START  = 180;
    localparam int SLIDE_STEP   = 20;
    localparam int SLIDE_END    = 50;
    localparam int INVULN       = 60;
    localparam int CENTRE       = (LANES - 1) / 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               frame_tick = 1'b0;
    logic               btn_left = 1'b0, btn_right = 1'b0, btn_start = 1'b0;
    logic [2:0]         coin_hit = '0;
    logic [3:0]         obst_hit = '0;
    game_state_t        state;
    logic [1:0]         player_lane;
    logic [11:0]        player_hoff;
    logic [11:0]        player_voff, logo_voff;
    logic [SCORE_W-1:0] score;
    logic [3:0]         lives;
    logic               invuln, spawn_en;

    always #5 clk = ~clk;

    game_fsm #(.SCORE_W(SCORE_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_start   (btn_start),
        .coin_hit    (coin_hit),
        .obst_hit    (obst_hit),
        .state       (state),
        .player_lane (player_lane),
        .player_hoff (player_hoff),
        .player_voff (player_voff),
        .logo_voff   (logo_voff),
        .score       (score),
        .lives       (lives),
        .invuln      (invuln),
        .spawn_en    (spawn_en)
    );

    typedef struct {
        logic [2:0]  st;
        logic [1:0]  lane;
        logic [11:0] hoff;
        logic [11:0] pvoff;
        logic [11:0] logo;
        logic [3:0]  score;
        logic [3:0]  lives;
        logic        inv;
        logic        spawn;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    bit   mon_sampled;

    // Reference model state, kept in plain integers.
    game_state_t m_state;
    int m_phase_left, m_lane, m_logo, m_pvoff, m_score, m_lives, m_inv;
    bit m_pl, m_pr, m_ps;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = IDLE;  m_phase_left = 0; m_lane = CENTRE;
        m_logo = 0;      m_pvoff = SLIDE_START;
        m_score = 0;     m_lives = LIVES;  m_inv = 0;
        m_pl = 0; m_pr = 0; m_ps = 0;
    endfunction

    function automatic void start_game();
        m_state = COUNTDOWN; m_phase_left = COUNT_FRAMES + 1; m_lane = CENTRE;
        m_logo = 0; m_pvoff = SLIDE_START; m_score = 0; m_lives = LIVES; m_inv = 0;
    endfunction

    function automatic void model_tick(input bit l, input bit r, input bit s,
                                       input logic [2:0] coin, input logic [3:0] obst);
        bit pl, pr, ps;
        pl = l && !m_pl;  pr = r && !m_pr;  ps = s && !m_ps;
        m_pl = l; m_pr = r; m_ps = s;
        case (m_state)
            IDLE, OVER: if (ps) start_game();
            COUNTDOWN: begin
                m_phase_left--;
                if (m_phase_left == 0) m_state = LOGO;
            end
            LOGO:  if (m_logo < FADE_END) m_logo += FADE_STEP; else m_state = SLIDE;
            SLIDE: if (m_pvoff > SLIDE_END) m_pvoff -= SLIDE_STEP; else m_state = PLAY;
            PLAY: begin
                if (pl && !pr && m_lane > 0)         m_lane--;
                if (pr && !pl && m_lane < LANES - 1) m_lane++;
                m_score += $countones(coin);
                if (m_score > SMAX) m_score = SMAX;
                if (obst != 0 && m_inv == 0) begin
                    m_lives--;
                    if (m_lives == 0) m_state = OVER;
                    else              m_inv = INVULN;
                end else if (m_inv > 0) begin
                    m_inv--;
                end
            end
            default: m_state = IDLE;
        endcase
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.st    = m_state;
        e.lane  = 2'(m_lane);
        e.hoff  = 12'((m_lane - CENTRE) * PITCH);
        e.pvoff = 12'(m_pvoff);
        e.logo  = 12'(m_logo);
        e.score = 4'(m_score);
        e.lives = 4'(m_lives);
        e.inv   = (m_inv > 0);
        e.spawn = (m_state == PLAY);
        return e;
    endfunction

    task automatic junk();
        btn_left  = 1'($urandom);
        btn_right = 1'($urandom);
        btn_start = 1'($urandom);
        coin_hit  = 3'($urandom);
        obst_hit  = 4'($urandom);
    endtask

    // Called at a falling edge; leaves the bench at a falling edge.
    task automatic do_reset(input bit with_tick);
        junk();
        rst = 1'b1;
        frame_tick = with_tick;
        model_reset();
        exp_q.push_back(model_out());
        @(negedge clk);
        rst = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic tick(input bit l, input bit r, input bit s,
                        input logic [2:0] coin, input logic [3:0] obst);
        btn_left = l; btn_right = r; btn_start = s;
        coin_hit = coin; obst_hit = obst;
        frame_tick = 1'b1;
        model_tick(l, r, s, coin, obst);
        exp_q.push_back(model_out());
        @(negedge clk);
        frame_tick = 1'b0;
        junk();
        @(negedge clk);
        if ($urandom_range(0, 1) == 1) begin
            junk();
            @(negedge clk);
        end
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 3'b000, 4'b0000);
    endtask

    task automatic wait_play();
        for (int i = 0; i < 100 && m_state != PLAY; i++) tick(0, 0, 0, 3'b000, 4'b0000);
        if (m_state != PLAY) begin
            n_miss++;
            $display("FAIL wait_play: PLAY not reached within 100 ticks");
        end
    endtask

    task automatic rand_tick();
        logic [3:0] obst;
        obst = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
        tick(1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0),
             3'($urandom), obst);
    endtask

    // Monitor: one expected entry per edge that saw rst or frame_tick.
    initial begin
        exp_t e;
        @(negedge clk);
        forever begin
            @(posedge clk);
            mon_sampled = (rst === 1'b1) || (frame_tick === 1'b1);
            @(negedge clk);
            if (mon_sampled) begin
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL scoreboard: DUT update with no expected entry (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("state",       state,       e.st);
                    check("player_lane", player_lane, e.lane);
                    check("player_hoff", player_hoff, e.hoff);
                    check("player_voff", player_voff, e.pvoff);
                    check("logo_voff",   logo_voff,   e.logo);
                    check("score",       score,       e.score);
                    check("lives",       lives,       e.lives);
                    check("invuln",      invuln,      e.inv);
                    check("spawn_en",    spawn_en,    e.spawn);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver.
    initial begin
        @(negedge clk);
        do_reset(1'b1);
        do_reset(1'b0);

        // Start-up sequence down to PLAY.
        tick(0, 0, 1, 3'b000, 4'b0000);
        check("start_state", state, COUNTDOWN);
        tick(0, 0, 0, 3'b000, 4'b0000);
        wait_play();
        check("play_logo",  logo_voff,   660);
        check("play_pvoff", player_voff, 40);
        check("play_spawn", spawn_en,    1);

        // Lane moves.
        tick(0, 1, 0, 3'b000, 4'b0000);
        check("right_lane", player_lane, 2);
        check("right_hoff", player_hoff, 100);
        tick(0, 0, 0, 3'b000, 4'b0000);
        tick(0, 1, 0, 3'b000, 4'b0000);
        check("edge_lane", player_lane, 2);
        tick(0, 0, 0, 3'b000, 4'b0000);
        tick(1, 1, 0, 3'b000, 4'b0000);
        check("both_lane", player_lane, 2);
        tick(0, 0, 0, 3'b000, 4'b0000);
        tick(1, 0, 0, 3'b000, 4'b0000);
        tick(1, 0, 0, 3'b000, 4'b0000);
        tick(1, 0, 0, 3'b000, 4'b0000);
        check("held_lane", player_lane, 1);
        tick(0, 0, 0, 3'b000, 4'b0000);
        tick(1, 0, 0, 3'b000, 4'b0000);
        check("left_hoff", player_hoff, 12'hF9C);
        tick(0, 0, 0, 3'b000, 4'b0000);
        tick(0, 1, 0, 3'b000, 4'b0000);
        tick(0, 0, 0, 3'b000, 4'b0000);

        // Score and saturation.
        tick(0, 0, 0, 3'b111, 4'b0000);
        check("score_3", score, 3);
        tick(0, 0, 0, 3'b111, 4'b0000);
        tick(0, 0, 0, 3'b111, 4'b0000);
        tick(0, 0, 0, 3'b111, 4'b0000);
        tick(0, 0, 0, 3'b011, 4'b0000);
        check("score_14", score, 14);
        tick(0, 0, 0, 3'b011, 4'b0000);
        check("score_sat", score, 15);
        tick(0, 0, 0, 3'b111, 4'b0000);
        check("score_hold", score, 15);

        // Lives and invulnerability.
        tick(0, 0, 0, 3'b000, 4'b1010);
        check("hit1_lives",  lives,  2);
        check("hit1_invuln", invuln, 1);
        idle_ticks(9);
        tick(0, 0, 0, 3'b000, 4'b0001);
        check("prot_lives", lives, 2);
        idle_ticks(49);
        check("inv_last", invuln, 1);
        idle_ticks(1);
        check("inv_clear", invuln, 0);
        tick(0, 0, 0, 3'b000, 4'b1111);
        check("hit2_lives", lives, 1);
        idle_ticks(60);
        tick(0, 0, 0, 3'b001, 4'b0100);
        check("over_state", state,    OVER);
        check("over_spawn", spawn_en, 0);
        check("over_score", score,    15);
        tick(1, 1, 0, 3'b111, 4'b1111);
        check("over_hold", score, 15);
        tick(0, 0, 1, 3'b000, 4'b0000);
        check("restart_state", state, COUNTDOWN);
        check("restart_score", score, 0);
        check("restart_lives", lives, 3);
        tick(0, 0, 0, 3'b000, 4'b0000);

        // Random play across several games.
        for (int i = 0; i < 1500; i++) rand_tick();

        // Reset asserted mid-game between ticks.
        tick(0, 0, 0, 3'b000, 4'b0000);
        tick(0, 0, 1, 3'b000, 4'b0000);
        tick(0, 0, 0, 3'b000, 4'b0000);
        wait_play();
        tick(0, 1, 0, 3'b011, 4'b0000);
        do_reset(1'b0);
        check("rst_state", state,       IDLE);
        check("rst_lane",  player_lane, 1);
        check("rst_lives", lives,       3);
        check("rst_pvoff", player_voff, 180);
        check("rst_spawn", spawn_en,    0);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard: %0d expected entries never consumed", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
